// File: rtl/bmp_stream_ctrl.sv
// bmp_stream_ctrl: validates a BMP header in-stream and forwards every byte through one output register, tagging pixel bytes, the last byte and header errors
module bmp_stream_ctrl #(
  parameter int unsigned MIN_OFFSET = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] mul_cfg,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_pix,
  output logic       m_last,
  input  logic       m_ready,
  output logic [2:0] mul_value,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, HDR, PIX, DONE, ERR} state_t;
  state_t state, state_d;
  logic [31:0] idx, file_size, data_offset, off_full;
  logic [4:0] sh;
  logic acc, arm, hdr_bad, to_pix, to_done;
  assign s_ready = (state == HDR || state == PIX) && (!m_valid || m_ready);
  assign acc = s_valid && s_ready;
  assign arm = start && (state == IDLE || state == DONE || state == ERR);
  assign sh = {idx[1:0] - 2'd2, 3'b000};
  assign off_full = {s_data, data_offset[23:0]};
  assign hdr_bad = (idx == 32'd0 && s_data != 8'h42) || (idx == 32'd1 && s_data != 8'h4D) ||
                   (idx == 32'd13 && (off_full < MIN_OFFSET || off_full >= file_size));
  assign to_pix = idx > 32'd13 && idx == data_offset - 32'd1;
  assign to_done = idx == file_size - 32'd1;
  assign done = m_valid && m_ready && m_last;
  assign busy = state == HDR || state == PIX || m_valid;
  assign err = state == ERR;
  always_comb begin
    state_d = state;
    if (arm)
      state_d = HDR;
    else if (acc && state == HDR)
      state_d = hdr_bad ? ERR : to_pix ? PIX : HDR;
    else if (acc && state == PIX)
      state_d = to_done ? DONE : PIX;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_value <= '0;
      idx <= '0;
      file_size <= '0;
      data_offset <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_pix <= 1'b0;
      m_last <= 1'b0;
    end else begin
      if (arm) begin
        mul_value <= mul_cfg;
        idx <= '0;
        file_size <= '0;
        data_offset <= '0;
      end else if (acc) begin
        idx <= idx + 32'd1;
        if (state == HDR && idx >= 32'd2 && idx <= 32'd5) file_size[sh +: 8] <= s_data;
        if (state == HDR && idx >= 32'd10 && idx <= 32'd13) data_offset[sh +: 8] <= s_data;
      end
      if (acc) begin
        m_valid <= 1'b1;
        m_data <= s_data;
        m_pix <= state == PIX;
        m_last <= state == PIX && to_done;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bmp_stream_ctrl.sv
// tb_bmp_stream_ctrl: random and directed BMP frames checked against a header-rule model
module tb_bmp_stream_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [2:0] mul_cfg = '0;
  logic [7:0] s_data = '0;
  logic s_ready, m_valid, m_pix, m_last, busy, done, err;
  logic [7:0] m_data;
  logic [2:0] mul_value;
  int total = 0, bad = 0;
  byte unsigned fr[256];
  int len;
  bmp_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mul_cfg(mul_cfg), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_pix(m_pix), .m_last(m_last),
    .m_ready(m_ready), .mul_value(mul_value), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic build(input int size, input int off, input byte unsigned b0, input byte unsigned b1);
    len = size;
    for (int i = 0; i < 256; i++) fr[i] = 8'($urandom);
    fr[0] = b0;
    fr[1] = b1;
    for (int i = 0; i < 4; i++) begin
      fr[2 + i] = 8'(size >> (8 * i));
      fr[10 + i] = 8'(off >> (8 * i));
    end
  endtask
  task automatic rst_check(input string tag);
    chk(tag, {s_ready, m_valid, m_data, m_pix, m_last, done, busy, err, mul_value}, 32'd0);
  endtask
  task automatic run_frame(input logic [2:0] mul, input int rmode, input int abort_at, input bit poke);
    int fs, off, nout, si, got, dcnt, cyc;
    bit eerr, prev_stall, poked;
    logic [9:0] prev_word, exp_word;
    fs = {fr[5], fr[4], fr[3], fr[2]};
    off = {fr[13], fr[12], fr[11], fr[10]};
    eerr = 1'b1;
    if (fr[0] != 8'h42) nout = 1;
    else if (fr[1] != 8'h4D) nout = 2;
    else if (off < 54 || off >= fs) nout = 14;
    else begin
      nout = fs;
      eerr = 1'b0;
    end
    si = 0; got = 0; dcnt = 0; cyc = 0; prev_stall = 0; poked = 0; prev_word = '0;
    @(negedge clk);
    mul_cfg = mul;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", busy, 1);
    while (!(got == nout && !m_valid)) begin
      if (cyc > 4000) begin
        chk("timeout", got, nout);
        break;
      end
      m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 2 == 0) : 1'($urandom);
      s_valid = si < len && (rmode != 2 || $urandom_range(3) != 0);
      s_data = fr[si];
      start = 1'b0;
      if (poke && si == 30 && !poked) begin
        start = 1'b1;
        mul_cfg = 3'd5;
        poked = 1;
      end
      #1;
      if (prev_stall) chk("hold", {m_valid, m_pix, m_last, m_data}, {1'b1, prev_word});
      if (m_valid && m_ready) begin
        if (got >= nout) chk("extra", got, nout);
        exp_word = {got >= off, got == fs - 1, fr[got]};
        chk("out", {m_pix, m_last, m_data}, exp_word);
        chk("done_at", done, got == fs - 1);
        got++;
      end
      dcnt += done;
      prev_stall = m_valid && !m_ready;
      prev_word = {m_pix, m_last, m_data};
      if (s_valid && s_ready) begin
        si++;
        if (si - 1 == abort_at) begin
          @(posedge clk);
          #2 rst = 1'b1;
          #1 rst_check("rst_mid");
          @(negedge clk);
          rst = 1'b0;
          s_valid = 1'b0;
          return;
        end
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    chk("err_end", err, eerr);
    chk("done_cnt", dcnt, eerr ? 0 : 1);
    chk("mul_value", mul_value, mul);
    chk("busy_end", busy, 0);
    chk("s_ready_end", s_ready, 0);
    s_valid = 1'b0;
  endtask
  initial begin
    int size, off, kind;
    repeat (2) @(negedge clk);
    rst_check("reset");
    rst = 1'b0;
    build(70, 54, 8'h42, 8'h4D);
    run_frame(3'd2, 0, -1, 0);
    run_frame(3'd2, 1, -1, 0);
    build(70, 54, 8'h41, 8'h4D);
    run_frame(3'd1, 0, -1, 0);
    build(70, 40, 8'h42, 8'h4D);
    run_frame(3'd4, 2, -1, 0);
    build(70, 54, 8'h42, 8'h4D);
    run_frame(3'd3, 0, -1, 0);
    run_frame(3'd2, 0, 60, 0);
    run_frame(3'd2, 2, -1, 0);
    build(100, 54, 8'h42, 8'h4D);
    run_frame(3'd2, 2, -1, 1);
    for (int n = 0; n < 24; n++) begin
      size = $urandom_range(200, 60);
      off = $urandom_range(size - 1, 54);
      kind = $urandom_range(7);
      if (kind == 0) build(size, off, 8'($urandom_range(255, 67)), 8'h4D);
      else if (kind == 1) build(size, off, 8'h42, 8'($urandom_range(76)));
      else if (kind == 2) build(size, $urandom_range(53, 14), 8'h42, 8'h4D);
      else if (kind == 3) build(size, size + $urandom_range(8), 8'h42, 8'h4D);
      else build(size, off, 8'h42, 8'h4D);
      run_frame(3'($urandom), $urandom_range(2), -1, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
